// File: rtl/multiplication_top.sv
// rtl/multiplication_top.sv - 64x64 unsigned radix-4 sequential multiplier, 129-bit registered result
// One operation takes 32 BUSY cycles, then one DONE cycle pulsing ready, then IDLE.

module multiplication_top (
   input  logic [63:0]  a_in,
   input  logic [63:0]  b_in,
   output logic [128:0] result,
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         ready
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [63:0]    a_reg;
   logic [65:0]    a3_reg;
   logic [63:0]    b_reg;
   logic [129:0]   acc;
   logic [4:0]     step;

   logic [65:0]    pp;
   logic [66:0]    sum_hi;
   logic [129:0]   acc_nxt;
   logic           last_step;

   // Partial product for the two lowest remaining multiplier bits.
   always_comb begin
      pp = '0;
      case (b_reg[1:0])
         2'd0:    pp = '0;
         2'd1:    pp = {2'b00, a_reg};
         2'd2:    pp = {1'b0, a_reg, 1'b0};
         default: pp = a3_reg;
      endcase
   end

   // Add into the upper half, then shift the whole accumulator right by two;
   // after 32 steps the low 128 bits hold the complete product.
   assign sum_hi    = {1'b0, acc[129:64]} + {1'b0, pp};
   assign acc_nxt   = {1'b0, sum_hi, acc[63:2]};
   assign last_step = (step == 5'd31);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         BUSY:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg  <= '0;
         a3_reg <= '0;
         b_reg  <= '0;
         acc    <= '0;
         step   <= '0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg  <= a_in;
                  a3_reg <= {2'b00, a_in} + {1'b0, a_in, 1'b0};
                  b_reg  <= b_in;
                  acc    <= '0;
                  step   <= '0;
               end
            end
            BUSY: begin
               acc   <= acc_nxt;
               b_reg <= b_reg >> 2;
               step  <= step + 5'd1;
               if (last_step) begin
                  result <= {1'b0, acc_nxt[127:0]};
                  ready  <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplication_top.sv
// tb/tb_multiplication_top.sv - directed self-checking bench for multiplication_top

module tb_multiplication_top;

   logic [63:0]  a_in;
   logic [63:0]  b_in;
   logic [128:0] result;
   logic         clk;
   logic         reset;
   logic         start;
   logic         ready;

   int passed = 0;
   int total  = 0;

   multiplication_top dut (
      .a_in   (a_in),
      .b_in   (b_in),
      .result (result),
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .ready  (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [128:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      p = {64'd0, a} * {64'd0, b};
      return {1'b0, p};
   endfunction

   // Starts one operation from IDLE and returns the result at the ready pulse.
   // edges counts rising edges with the accept edge as edge 1.
   task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                        output logic [128:0] res, output int edges);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      start = 1'b0;
      a_in  = ~a;
      b_in  = b ^ 64'hA5A5_5A5A_F00F_0FF0;
      while (!ready && edges < 60) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 12) begin
            a_in  = 64'h1;
            start = 1'b1;
         end
         if (edges == 14) start = 1'b0;
      end
      res = result;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      a_in  = 64'd9;
      b_in  = 64'd9;
      repeat (3) @(negedge clk);
      total++;
      if (result !== 129'd0) $display("FAIL reset_result actual=%h required=0", result);
      else passed++;
      total++;
      if (ready !== 1'b0) $display("FAIL reset_ready actual=%b required=0", ready);
      else passed++;
      start = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [128:0] res;
      int           edges;
      do_op(64'd17, 64'd27, res, edges);
      total++;
      if (res !== 129'd459) $display("FAIL basic_result actual=%0d required=459", res);
      else passed++;
      total++;
      if (edges !== 33) $display("FAIL basic_latency actual=%0d required=33", edges);
      else passed++;
      @(negedge clk);
      total++;
      if (ready !== 1'b0) $display("FAIL basic_ready_drop actual=%b required=0", ready);
      else passed++;
      total++;
      if (result !== 129'd459) $display("FAIL basic_hold actual=%0d required=459", result);
      else passed++;
   endtask

   task automatic test_max();
      logic [128:0] res;
      int           edges;
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, res, edges);
      total++;
      if (res !== 129'h0_FFFFFFFFFFFFFFFE_0000000000000001)
         $display("FAIL max_result actual=%h required=0fffffffffffffffe0000000000000001", res);
      else passed++;
      total++;
      if (res[128] !== 1'b0) $display("FAIL max_msb actual=%b required=0", res[128]);
      else passed++;
   endtask

   task automatic test_zero_one();
      logic [128:0] res;
      int           edges;
      do_op(64'd0, 64'h1234_5678_9ABC_DEF0, res, edges);
      total++;
      if (res !== 129'd0) $display("FAIL zero_result actual=%h required=0", res);
      else passed++;
      do_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, res, edges);
      total++;
      if (res !== 129'h0_0000000000000000_FFFFFFFFFFFFFFFF)
         $display("FAIL one_result actual=%h required=ffffffffffffffff", res);
      else passed++;
   endtask

   task automatic test_operand_change();
      logic [128:0] res;
      int           edges;
      do_op(64'd1000, 64'd3000, res, edges);
      total++;
      if (res !== 129'd3000000) $display("FAIL operand_change actual=%0d required=3000000", res);
      else passed++;
      do_op(64'hDEAD_BEEF_0000_0001, 64'd2, res, edges);
      total++;
      if (res !== 129'h0_0000000000000001_BD5B7DDE00000002)
         $display("FAIL operand_change_2 actual=%h required=1bd5b7dde00000002", res);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      logic [63:0] b;
      int          edges;
      bit          timed_out;
      a = 64'h0123_4567_89AB_CDEF;
      b = 64'hFEDC_BA98_7654_3210;
      timed_out = 1'b0;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      edges = 0;
      for (int op = 0; op < 100 && !timed_out; op++) begin
         do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
         end while (!ready && edges < 40);
         if (!ready) begin
            total++;
            $display("FAIL b2b_timeout op=%0d edges=%0d required_ready=1", op, edges);
            timed_out = 1'b1;
         end else begin
            total++;
            if (result !== ref_mul(a, b))
               $display("FAIL b2b_result op=%0d actual=%h required=%h", op, result, ref_mul(a, b));
            else passed++;
            total++;
            if (edges !== (op == 0 ? 33 : 34))
               $display("FAIL b2b_period op=%0d actual=%0d required=%0d", op, edges, (op == 0 ? 33 : 34));
            else passed++;
            a     = a * 64'd17;
            b     = a + b * 64'd3;
            a_in  = a;
            b_in  = b;
            edges = 0;
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic [128:0] res;
      int           edges;
      int           pulses;
      do_op(64'd11, 64'd13, res, edges);
      total++;
      if (res !== 129'd143) $display("FAIL abort_prior actual=%0d required=143", res);
      else passed++;
      @(negedge clk);
      a_in  = 64'd5;
      b_in  = 64'd7;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (result !== 129'd0) $display("FAIL abort_result actual=%0d required=0", result);
      else passed++;
      total++;
      if (ready !== 1'b0) $display("FAIL abort_ready actual=%b required=0", ready);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      total++;
      if (pulses !== 0) $display("FAIL abort_no_pulse actual=%0d required=0", pulses);
      else passed++;
      do_op(64'd6, 64'd7, res, edges);
      total++;
      if (res !== 129'd42) $display("FAIL after_reset_result actual=%0d required=42", res);
      else passed++;
      total++;
      if (edges !== 33) $display("FAIL after_reset_latency actual=%0d required=33", edges);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_zero_one();
      test_operand_change();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
